// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK flip-flop command sequencer:
// opcodes, FSM state encoding and the default command layout.
package jk_seq_pkg;

    // cmd_op is {j,k}, so each opcode is also the drive pattern it produces.
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam int CMD_RPT_W = 4;

    typedef struct packed {
        logic [1:0]           op;
        logic [CMD_RPT_W-1:0] rpt;
    } cmd_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO of command entries. DEPTH must be a power of two so
// the pointers wrap naturally.
module jk_cmd_fifo
    import jk_seq_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type item_t = cmd_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  item_t                  wdata,
    input  logic                   pop,
    output item_t                  rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    item_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately left unreset; pointers and count alone
    // decide which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_seq_driver.sv
// Command sequencer driving a downstream JK flip-flop, with a shadow copy
// of its state and a sticky flag for divergence from the fed-back q.
module jk_seq_driver
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RPT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [RPT_W-1:0]       cmd_rpt,
    output logic                   j,
    output logic                   k,
    input  logic                   q_fb,
    output logic                   q_pred,
    input  logic                   err_clr,
    output logic                   mismatch,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    // Same layout as cmd_t, but with the repeat field sized by RPT_W.
    typedef struct packed {
        logic [1:0]       op;
        logic [RPT_W-1:0] rpt;
    } cmd_req_t;

    cmd_req_t         wcmd;
    cmd_req_t         head;
    logic             full;
    logic             empty;
    logic             pop;
    state_t           state;
    logic [RPT_W-1:0] rpt_cnt;
    logic             chk_en;

    assign wcmd      = '{op: cmd_op, rpt: cmd_rpt};
    assign cmd_ready = !full;
    assign busy      = (state == ST_RUN);
    // Loading the next command on the last repeat cycle keeps commands gap-free.
    assign pop       = !empty && ((state == ST_IDLE) || (rpt_cnt == '0));

    jk_cmd_fifo #(
        .DEPTH  (DEPTH),
        .item_t (cmd_req_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            j       <= 1'b0;
            k       <= 1'b0;
            rpt_cnt <= '0;
        end else if (pop) begin
            state    <= ST_RUN;
            {j, k}   <= head.op;
            rpt_cnt  <= head.rpt;
        end else if (state == ST_RUN) begin
            if (rpt_cnt != '0) begin
                rpt_cnt <= rpt_cnt - 1'b1;
            end else begin
                state <= ST_IDLE;
                j     <= 1'b0;
                k     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_pred <= 1'b0;
        end else begin
            case ({j, k})
                OP_HOLD:   q_pred <= q_pred;
                OP_RESET:  q_pred <= 1'b0;
                OP_SET:    q_pred <= 1'b1;
                OP_TOGGLE: q_pred <= ~q_pred;
            endcase
        end
    end

    // chk_en masks the first edge after reset release while q_fb settles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chk_en <= 1'b0;
        else      chk_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch <= 1'b0;
        end else if (chk_en && (q_fb != q_pred)) begin
            mismatch <= 1'b1;
        end else if (err_clr) begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed bench: jk_seq_driver driving a JK flip-flop whose q loops back
// to q_fb, with an injection point for forcing a divergent q_fb.
module tb_jk_seq_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rpt;
    logic       j;
    logic       k;
    logic       q;
    logic       q_fb;
    logic       q_pred;
    logic       err_clr;
    logic       mismatch;
    logic       busy;
    logic [2:0] fifo_cnt;
    logic       inject;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jk_seq_driver #(.DEPTH(4), .RPT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rpt   (cmd_rpt),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .q_pred    (q_pred),
        .err_clr   (err_clr),
        .mismatch  (mismatch),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt)
    );

    // Downstream JK flip-flop sharing the sequencer's reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= 1'b0;
        else begin
            case ({j, k})
                2'b00: q <= q;
                2'b01: q <= 1'b0;
                2'b10: q <= 1'b1;
                2'b11: q <= ~q;
            endcase
        end
    end

    assign q_fb = q ^ inject;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " jk"},       32'({j, k}),    32'd0);
        chk({tag, " q_pred"},   32'(q_pred),    32'd0);
        chk({tag, " mismatch"}, 32'(mismatch),  32'd0);
        chk({tag, " busy"},     32'(busy),      32'd0);
        chk({tag, " fifo_cnt"}, 32'(fifo_cnt),  32'd0);
        chk({tag, " ready"},    32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_jk  [7];
        int exp_cnt [7];
        exp_jk  = '{2, 1, 1, 3, 0, 0, 0};
        exp_cnt = '{3, 2, 2, 1, 0, 0, 0};

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rpt = 4'd0;
        err_clr = 1'b0; inject = 1'b0;
        #3;
        check_reset_state("por");
        #9 rst = 1'b1;
        step();

        // Single SET, rpt=0
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rpt = 4'd0;
        step();                               // E0: push
        cmd_valid = 1'b0;
        chk("single cnt E0",  32'(fifo_cnt), 32'd1);
        chk("single jk E0",   32'({j, k}),   32'd0);
        step();                               // E1: load
        chk("single jk E1",   32'({j, k}),   32'd2);
        chk("single busy E1", 32'(busy),     32'd1);
        chk("single qp E1",   32'(q_pred),   32'd0);
        step();                               // E2
        chk("single jk E2",   32'({j, k}),   32'd0);
        chk("single qp E2",   32'(q_pred),   32'd1);
        chk("single q E2",    32'(q_fb),     32'd1);
        chk("single busy E2", 32'(busy),     32'd0);
        step();
        chk("single mismatch", 32'(mismatch), 32'd0);

        // Reset pulse so the toggle run starts from q=0
        rst = 1'b0;
        #2;
        check_reset_state("pulse");
        rst = 1'b1;
        step();

        // TOGGLE, rpt=3
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'd3;
        step();
        cmd_valid = 1'b0;
        step();
        chk("tog jk E1",   32'({j, k}), 32'd3);
        chk("tog busy E1", 32'(busy),   32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("tog q %0d", i), 32'(q_fb),   (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("tog qp %0d", i), 32'(q_pred), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("tog jk %0d", i), 32'({j, k}), (i < 3) ? 32'd3 : 32'd0);
            chk($sformatf("tog busy %0d", i), 32'(busy), (i < 3) ? 32'd1 : 32'd0);
        end

        // Fill while a HOLD/15 stalls the FIFO, then drain back-to-back
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rpt = 4'd15;
        step();                               // E0
        cmd_op = 2'b10; cmd_rpt = 4'd0;
        step();                               // E1: HOLD loaded, SET pushed
        cmd_op = 2'b01; cmd_rpt = 4'd1;
        step();                               // E2
        cmd_op = 2'b11; cmd_rpt = 4'd0;
        step();                               // E3
        cmd_op = 2'b00; cmd_rpt = 4'd2;
        step();                               // E4
        chk("fill cnt",   32'(fifo_cnt),  32'd4);
        chk("fill ready", 32'(cmd_ready), 32'd0);
        cmd_op = 2'b10; cmd_rpt = 4'd0;       // fifth push, must be refused
        step();                               // E5
        cmd_valid = 1'b0;
        chk("fifth refused cnt", 32'(fifo_cnt), 32'd4);
        repeat (11) step();                   // to E16, last HOLD cycle
        chk("hold jk E16",   32'({j, k}), 32'd0);
        chk("hold busy E16", 32'(busy),   32'd1);
        chk("hold cnt E16",  32'(fifo_cnt), 32'd4);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("drain jk %0d", i),  32'({j, k}),   32'(exp_jk[i]));
            chk($sformatf("drain cnt %0d", i), 32'(fifo_cnt), 32'(exp_cnt[i]));
            chk($sformatf("drain busy %0d", i), 32'(busy),    32'd1);
        end
        step();
        chk("drain idle busy", 32'(busy),     32'd0);
        chk("drain idle jk",   32'({j, k}),   32'd0);
        chk("drain qp",        32'(q_pred),   32'd1);
        chk("drain mismatch",  32'(mismatch), 32'd0);

        // Fault injection on q_fb
        inject = 1'b1;
        #1;
        chk("inj not yet", 32'(mismatch), 32'd0);
        step();
        inject = 1'b0;
        chk("inj set", 32'(mismatch), 32'd1);
        step();
        chk("inj sticky", 32'(mismatch), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("inj cleared", 32'(mismatch), 32'd0);
        inject = 1'b1; err_clr = 1'b1;
        step();
        inject = 1'b0; err_clr = 1'b0;
        chk("set beats clr", 32'(mismatch), 32'd1);
        step();
        chk("set beats clr sticky", 32'(mismatch), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("final clr", 32'(mismatch), 32'd0);

        // Reset during TOGGLE/7 with two commands queued
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rpt = 4'd7;
        step();
        cmd_op = 2'b10; cmd_rpt = 4'd0;
        step();
        cmd_op = 2'b01; cmd_rpt = 4'd0;
        step();
        cmd_valid = 1'b0;
        chk("mid busy",  32'(busy),     32'd1);
        chk("mid cnt",   32'(fifo_cnt), 32'd2);
        chk("mid jk",    32'({j, k}),   32'd3);
        #1 rst = 1'b0;
        #1;
        check_reset_state("mid rst");
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("post rst mismatch", 32'(mismatch), 32'd0);
        chk("post rst jk",       32'({j, k}),   32'd0);
        chk("post rst cnt",      32'(fifo_cnt), 32'd0);
        chk("post rst busy",     32'(busy),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_seq_driver.md
# jk_seq_driver

Command sequencer that sits directly upstream of the team's JK flip-flop and produces its `j`/`k` control inputs. It accepts hold/reset/set/toggle commands with repeat counts over a valid/ready handshake and buffers them in a small FIFO. It drives registered `j`/`k` one command-cycle per clock. It also keeps a shadow model of the flip-flop's `q` and flags any divergence from the real `q` fed back to it.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO depth; power of two, at least 2.
- `RPT_W`, default 4: repeat-count field width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept a command; equals `!full`.
- `cmd_op`  in  2  `{j,k}`: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- `cmd_rpt`  in  RPT_W  apply the op for `cmd_rpt+1` consecutive cycles.
- `j`, `k`  out  1 each  registered drive to the downstream flip-flop.
- `q_fb`  in  1  `q` fed back from the downstream flip-flop.
- `q_pred`  out  1  shadow model of the flip-flop state.
- `err_clr`  in  1  clears `mismatch`.
- `mismatch`  out  1  sticky divergence flag.
- `busy`  out  1  high in RUN.
- `fifo_cnt`  out  $clog2(DEPTH)+1  occupied FIFO entries.

## Operation
- **Push:** a command is written when `cmd_valid && cmd_ready`. `cmd_ready` depends on registered state only; there is no combinational path from pop to ready.
- **FSM states:**
  - IDLE: `j=k=0`.
    - FIFO non-empty → pop head, load `j,k=cmd_op`, set `rpt_cnt=cmd_rpt`, go to RUN.
  - RUN:
    - `rpt_cnt!=0` → decrement `rpt_cnt`; `j`/`k` unchanged.
    - `rpt_cnt==0` and FIFO non-empty → pop and load the next command with no bubble.
    - `rpt_cnt==0` and FIFO empty → `j=k=0`, go to IDLE.
- **Shadow model:** updates every edge from the current registered `j`,`k`:
  - 00: hold.
  - 01: 0.
  - 10: 1.
  - 11: `~q_pred`.
- **Check enable:** `chk_en` is cleared by reset and set on the first edge after `rst` deasserts.
- **Mismatch:** on each edge with `chk_en=1`, `q_fb!=q_pred` sets `mismatch`.
  - `err_clr` clears it.
  - When set and clear coincide, set wins.
- **Full FIFO:** push plus pop in the same cycle is impossible, because `cmd_ready=0` when full. A pop while full simply frees one slot.
- **Empty FIFO:** behaviour is as given under IDLE and RUN above; no underflow is possible.
- **Pointers:** FIFO pointers wrap modulo `DEPTH`. `fifo_cnt` ranges 0..DEPTH.

## Timing
- **Reset values:** while `rst` is low, all state clears asynchronously:
  - `j=k=0`, `q_pred=0`, `mismatch=0`, `busy=0`, `fifo_cnt=0`, `cmd_ready=1`.
  - State is IDLE and `chk_en=0`.
- **Reset mid-operation:** discards all FIFO contents and the in-flight repeat. Outputs return to the reset values above.
- **Latency:**
  - Push accepted at edge E0 into an empty FIFO while IDLE.
  - `j`/`k` are valid after E1.
  - The flip-flop and `q_pred` update at E2.
- **Duration:** a command with `cmd_rpt=N` holds `j`/`k` for exactly N+1 cycles.
- **Back-to-back commands:** contiguous, with zero idle cycles between them.
- **Mismatch timing:** `mismatch` asserts on the edge after the first cycle in which `q_fb!=q_pred` is observed with `chk_en=1`.

## Structure
- Package `jk_seq_pkg`:
  - `cmd_op` localparams `OP_HOLD`, `OP_RESET`, `OP_SET`, `OP_TOGGLE`.
  - FSM state typedef (`ST_IDLE`, `ST_RUN`).
  - Packed command struct `{op, rpt}`.
- Sub-module `jk_cmd_fifo`:
  - Parameterised synchronous FIFO of command structs.
  - Provides `full`, `empty`, `count`, `push` and `pop`.
- Top level contains the FSM, repeat counter, shadow model and mismatch logic.
- Verification instantiates `jk_seq_driver` together with the existing JK flip-flop, with `q` looped back to `q_fb`.

## Test plan
- **Single command:** reset, then push SET with rpt=0 → `j,k=10` for exactly 1 cycle, then 00. `q_pred=q_fb=1` from E2; `mismatch=0`.
- **Repeated toggle:** push TOGGLE with rpt=3 → `j=k=1` for 4 cycles. `q` sequence 1,0,1,0; `busy` low after the fourth cycle.
- **Fill and back-to-back:**
  - Push SET/0, RESET/1, TOGGLE/0 and HOLD/2 while stalled → the fifth push sees `cmd_ready=0`.
  - Drained `j,k` sequence is 10, 01, 01, 11, 00, 00, 00, with no gaps.
  - `fifo_cnt` counts 4→0.
- **Fault injection:** force `q_fb` opposite to `q_pred` for 1 cycle → `mismatch=1` and stays set. Assert `err_clr` and `mismatch` clears. Assert set and clear together and `mismatch` stays 1.
- **Mid-operation reset:** drop `rst` during a TOGGLE with rpt=7 and FIFO count 2 → immediately `j=k=0`, `fifo_cnt=0`, `q_pred=0`. After release, no spurious `mismatch`.
